// File: rtl/ra_cfg_pkg.sv
// Shared types for the config-register controller: FSM encoding, address width
// and the target slice position helper.
`ifndef LCBSDR_CONFIGWIDTH
`define LCBSDR_CONFIGWIDTH 8
`endif

package ra_cfg_pkg;

   localparam int ADDR_W = 3;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      WR   = 3'd1,
      CHK  = 3'd2,
      RD   = 3'd3,
      RSP  = 3'd4
   } state_t;

   // Target 0 sits in the MSBs of the concatenated readback bus.
   function automatic int tgt_lsb(input int idx, input int num_tgt, input int cw);
      return (num_tgt - 1 - idx) * cw;
   endfunction

endpackage

// File: rtl/ra_cfg_ctl_if.sv
// Host request/response bundle for ra_cfg_ctl; the host drives master, the
// controller takes slave.
interface ra_cfg_ctl_if #(
   parameter int CW = `LCBSDR_CONFIGWIDTH
);
   import ra_cfg_pkg::*;

   logic              req_val;
   logic              req_rdy;
   logic              req_rd;
   logic              req_bcast;
   logic [ADDR_W-1:0] req_addr;
   logic [CW-1:0]     req_dat;
   logic              rsp_val;
   logic              rsp_rdy;
   logic [CW-1:0]     rsp_dat;
   logic              rsp_err;

   modport master (
      output req_val, req_rd, req_bcast, req_addr, req_dat, rsp_rdy,
      input  req_rdy, rsp_val, rsp_dat, rsp_err
   );

   modport slave (
      input  req_val, req_rd, req_bcast, req_addr, req_dat, rsp_rdy,
      output req_rdy, rsp_val, rsp_dat, rsp_err
   );

endinterface

// File: rtl/ra_cfg_mux.sv
// Selects one CW-wide target readback slice from the concatenated cfg_in bus;
// an index beyond NUM_TGT returns zero.
module ra_cfg_mux
   import ra_cfg_pkg::*;
#(
   parameter int NUM_TGT = 6,
   parameter int CW      = `LCBSDR_CONFIGWIDTH
) (
   input  logic [NUM_TGT*CW-1:0] cfg_in,
   input  logic [ADDR_W-1:0]     idx,
   output logic [CW-1:0]         slice
);

   always_comb begin
      slice = '0;
      for (int i = 0; i < NUM_TGT; i++) begin
         if (idx == ADDR_W'(i)) begin
            slice = cfg_in[tgt_lsb(i, NUM_TGT, CW) +: CW];
         end
      end
   end

endmodule

// File: rtl/ra_cfg_ctl.sv
// Config-register write/readback controller. Optional broadcast writes are
// enabled by defining RA_CFG_CTL_BCAST_EN.
//
// state | meaning
// IDLE  | ready for a host request
// WR    | strobe cfg_wr for the latched target(s)
// CHK   | capture readback and compare against written data
// RD    | capture readback of the addressed target
// RSP   | hold response until the host takes it
module ra_cfg_ctl
   import ra_cfg_pkg::*;
#(
   parameter int NUM_TGT = 6,
   parameter int CW      = `LCBSDR_CONFIGWIDTH
) (
   input  logic                  clk,
   input  logic                  reset_n,
   ra_cfg_ctl_if.slave           bus,
   output logic [NUM_TGT-1:0]    cfg_wr,
   output logic [CW-1:0]         cfg_dat,
   input  logic [NUM_TGT*CW-1:0] cfg_in,
   output logic [7:0]            err_cnt
);

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0]     dat_q, dat_d;
   logic              bcast_q, bcast_d;
   logic [CW-1:0]     rsp_dat_q, rsp_dat_d;
   logic              rsp_err_q, rsp_err_d;
   logic [7:0]        err_cnt_q, err_cnt_d;

   logic              bcast_req;
   logic [ADDR_W-1:0] mux_idx;
   logic [CW-1:0]     sel_slice;
   logic              all_mis;

`ifdef RA_CFG_CTL_BCAST_EN
   assign bcast_req = bus.req_bcast & ~bus.req_rd;
`else
   logic unused_bcast;
   assign bcast_req    = 1'b0;
   assign unused_bcast = bus.req_bcast;
`endif

   // A broadcast reports target 0's readback.
   assign mux_idx = bcast_q ? '0 : addr_q;

   ra_cfg_mux #(
      .NUM_TGT (NUM_TGT),
      .CW      (CW)
   ) u_mux (
      .cfg_in (cfg_in),
      .idx    (mux_idx),
      .slice  (sel_slice)
   );

   always_comb begin
      all_mis = 1'b0;
      for (int i = 0; i < NUM_TGT; i++) begin
         if (cfg_in[tgt_lsb(i, NUM_TGT, CW) +: CW] != dat_q) begin
            all_mis = 1'b1;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      dat_d     = dat_q;
      bcast_d   = bcast_q;
      rsp_dat_d = rsp_dat_q;
      rsp_err_d = rsp_err_q;
      err_cnt_d = err_cnt_q;

      case (state_q)
         IDLE: begin
            if (bus.req_val) begin
               addr_d  = bus.req_addr;
               dat_d   = bus.req_dat;
               bcast_d = bcast_req;
               if (!bcast_req && (int'(bus.req_addr) >= NUM_TGT)) begin
                  rsp_dat_d = '0;
                  rsp_err_d = 1'b1;
                  state_d   = RSP;
               end else if (bus.req_rd) begin
                  state_d = RD;
               end else begin
                  state_d = WR;
               end
            end
         end
         WR: state_d = CHK;
         CHK: begin
            rsp_dat_d = sel_slice;
            rsp_err_d = bcast_q ? all_mis : (sel_slice != dat_q);
            state_d   = RSP;
         end
         RD: begin
            rsp_dat_d = sel_slice;
            rsp_err_d = 1'b0;
            state_d   = RSP;
         end
         RSP: begin
            if (bus.rsp_rdy) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if ((state_d == RSP) && (state_q != RSP) && rsp_err_d && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         dat_q     <= '0;
         bcast_q   <= 1'b0;
         rsp_dat_q <= '0;
         rsp_err_q <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         dat_q     <= dat_d;
         bcast_q   <= bcast_d;
         rsp_dat_q <= rsp_dat_d;
         rsp_err_q <= rsp_err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   // Strobes decode straight from the state register so reset kills them at once.
   always_comb begin
      cfg_wr = '0;
      for (int i = 0; i < NUM_TGT; i++) begin
         cfg_wr[i] = (state_q == WR) && (bcast_q || (addr_q == ADDR_W'(i)));
      end
   end

   assign cfg_dat     = dat_q;
   assign bus.req_rdy = (state_q == IDLE);
   assign bus.rsp_val = (state_q == RSP);
   assign bus.rsp_dat = rsp_dat_q;
   assign bus.rsp_err = rsp_err_q;
   assign err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_ra_cfg_ctl.sv
// Scoreboard bench for ra_cfg_ctl with behavioural config registers on cfg_wr/cfg_in.
module tb_ra_cfg_ctl;

   localparam int NUM_TGT = 6;
   localparam int CW      = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   ra_cfg_ctl_if #(.CW(CW)) bus();

   logic [NUM_TGT-1:0]    cfg_wr;
   logic [CW-1:0]         cfg_dat;
   logic [NUM_TGT*CW-1:0] cfg_in;
   logic [7:0]            err_cnt;

   ra_cfg_ctl #(.NUM_TGT(NUM_TGT), .CW(CW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus),
      .cfg_wr  (cfg_wr),
      .cfg_dat (cfg_dat),
      .cfg_in  (cfg_in),
      .err_cnt (err_cnt)
   );

   logic [CW-1:0] tgt [NUM_TGT];
   logic          stuck3 = 1'b0;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_TGT; i++) tgt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_TGT; i++) if (cfg_wr[i]) tgt[i] <= cfg_dat;
      end
   end

   always_comb begin
      cfg_in = '0;
      for (int i = 0; i < NUM_TGT; i++)
         cfg_in[(NUM_TGT-1-i)*CW +: CW] = (stuck3 && i == 3) ? '0 : tgt[i];
   end

   typedef struct {
      logic [CW-1:0] dat;
      logic          err;
      int            lat;
      int            acc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int total = 0;
   int bad = 0;
   int cyc = 0;
   int wr_cycles = 0;
   logic [NUM_TGT-1:0] wr_or = '0;
   logic rv_prev = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (!reset_n) begin
         rv_prev = 1'b0;
      end else begin
         if (cfg_wr != '0) begin
            wr_cycles++;
            wr_or |= cfg_wr;
         end
         if (bus.rsp_val && !rv_prev) begin
            if (sb.size() == 0) begin
               chk("unexpected_rsp", sb.size(), 1);
            end else begin
               mon_e = sb.pop_front();
               chk("rsp_dat", bus.rsp_dat, mon_e.dat);
               chk("rsp_err", bus.rsp_err, mon_e.err);
               chk("latency", cyc - mon_e.acc, mon_e.lat);
            end
         end
         rv_prev = bus.rsp_val;
      end
   end

   // Returns #1 after the accepting edge with req_val already dropped.
   task automatic send_req(input logic rd, input logic bc, input logic [2:0] addr,
                           input logic [CW-1:0] dat, input logic push,
                           input logic [CW-1:0] edat, input logic eerr, input int elat);
      int ok;
      int acc;
      ok = 0;
      @(negedge clk);
      wr_cycles = 0;
      wr_or = '0;
      bus.req_val = 1'b1;
      bus.req_rd = rd;
      bus.req_bcast = bc;
      bus.req_addr = addr;
      bus.req_dat = dat;
      for (int n = 0; n < 20; n++) begin
         if (bus.req_rdy) begin
            ok = 1;
            break;
         end
         @(negedge clk);
      end
      chk("accept", ok, 1);
      acc = cyc;
      @(posedge clk);
      #1;
      bus.req_val = 1'b0;
      if (push) sb.push_back('{dat: edat, err: eerr, lat: elat, acc: acc});
   endtask

   task automatic wait_rsp();
      int ok;
      ok = 0;
      for (int n = 0; n < 30; n++) begin
         @(negedge clk);
         if (bus.rsp_val && bus.rsp_rdy) begin
            ok = 1;
            break;
         end
      end
      chk("rsp_handshake", ok, 1);
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic rd, input logic bc, input logic [2:0] addr,
                         input logic [CW-1:0] dat, input logic [CW-1:0] edat,
                         input logic eerr, input int elat, input logic [NUM_TGT-1:0] ewr);
      send_req(rd, bc, addr, dat, 1'b1, edat, eerr, elat);
      wait_rsp();
      chk("wr_pattern", wr_or, ewr);
      chk("wr_cycles", wr_cycles, (ewr != '0) ? 1 : 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int sbad;
      int ok;
      bus.req_val = 1'b0;
      bus.req_rd = 1'b0;
      bus.req_bcast = 1'b0;
      bus.req_addr = '0;
      bus.req_dat = '0;
      bus.rsp_rdy = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_req_rdy", bus.req_rdy, 1);
      chk("rst_rsp_val", bus.rsp_val, 0);
      chk("rst_rsp_dat", bus.rsp_dat, 0);
      chk("rst_rsp_err", bus.rsp_err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      chk("rst_cfg_wr", cfg_wr, 0);
      chk("rst_cfg_dat", cfg_dat, 0);
      reset_n = 1'b1;

      // writes, readbacks, boundary targets
      do_req(0, 0, 3'd2, 8'h5A, 8'h5A, 0, 3, 6'b000100);
      do_req(1, 0, 3'd2, 8'h00, 8'h5A, 0, 2, 6'b000000);
      do_req(0, 0, 3'd0, 8'hA5, 8'hA5, 0, 3, 6'b000001);
      do_req(0, 0, 3'd5, 8'h3C, 8'h3C, 0, 3, 6'b100000);
      do_req(1, 0, 3'd0, 8'h00, 8'hA5, 0, 2, 6'b000000);
      do_req(1, 0, 3'd5, 8'h00, 8'h3C, 0, 2, 6'b000000);
      do_req(1, 0, 3'd1, 8'h00, 8'h00, 0, 2, 6'b000000);
      chk("err_cnt_clean", err_cnt, 0);

      // out-of-range addresses
      do_req(0, 0, 3'd7, 8'h12, 8'h00, 1, 1, 6'b000000);
      chk("err_cnt_bad_addr", err_cnt, 1);
      do_req(1, 0, 3'd6, 8'h00, 8'h00, 1, 1, 6'b000000);
      chk("err_cnt_bad_rd", err_cnt, 2);

      // stuck target 3 and saturation
      stuck3 = 1'b1;
      do_req(0, 0, 3'd3, 8'hFF, 8'h00, 1, 3, 6'b001000);
      chk("err_cnt_stuck", err_cnt, 3);
      for (int k = 0; k < 300; k++) do_req(0, 0, 3'd3, 8'hFF, 8'h00, 1, 3, 6'b001000);
      chk("err_cnt_sat", err_cnt, 255);
      stuck3 = 1'b0;

      // response stall with a competing request
      bus.rsp_rdy = 1'b0;
      send_req(0, 0, 3'd4, 8'h77, 1'b1, 8'h77, 0, 3);
      ok = 0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (bus.rsp_val) begin
            ok = 1;
            break;
         end
      end
      chk("stall_rsp_seen", ok, 1);
      sbad = 0;
      for (int k = 0; k < 10; k++) begin
         bus.req_val = 1'b1;
         bus.req_rd = 1'b0;
         bus.req_addr = 3'd1;
         bus.req_dat = 8'hEE;
         @(negedge clk);
         if (!bus.rsp_val || bus.rsp_dat !== 8'h77 || bus.rsp_err !== 1'b0 || bus.req_rdy !== 1'b0)
            sbad++;
      end
      chk("stall_stable", sbad, 0);
      bus.req_val = 1'b0;
      bus.rsp_rdy = 1'b1;
      @(posedge clk);
      #1;
      chk("stall_release_val", bus.rsp_val, 0);
      chk("stall_release_rdy", bus.req_rdy, 1);
      chk("stall_wr_pattern", wr_or, 6'b010000);
      chk("stall_wr_cycles", wr_cycles, 1);
      do_req(1, 0, 3'd4, 8'h00, 8'h77, 0, 2, 6'b000000);
      do_req(1, 0, 3'd1, 8'h00, 8'h00, 0, 2, 6'b000000);

      // reset during WR
      send_req(0, 0, 3'd1, 8'h11, 1'b0, 8'h00, 0, 0);
      chk("wr_in_wr", cfg_wr, 6'b000010);
      #1;
      reset_n = 1'b0;
      #1;
      chk("rst_mid_cfg_wr", cfg_wr, 0);
      chk("rst_mid_rsp_val", bus.rsp_val, 0);
      chk("rst_mid_err_cnt", err_cnt, 0);
      chk("rst_mid_cfg_dat", cfg_dat, 0);
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_no_rsp", bus.rsp_val, 0);
      chk("rst_no_wr", wr_cycles, 0);
      chk("rst_sb_empty", sb.size(), 0);
      do_req(1, 0, 3'd1, 8'h00, 8'h00, 0, 2, 6'b000000);

`ifdef RA_CFG_CTL_BCAST_EN
      do_req(0, 1, 3'd5, 8'h33, 8'h33, 0, 3, 6'b111111);
      for (int t = 0; t < NUM_TGT; t++) do_req(1, 0, 3'(t), 8'h00, 8'h33, 0, 2, 6'b000000);
`else
      do_req(0, 1, 3'd1, 8'h33, 8'h33, 0, 3, 6'b000010);
      do_req(1, 0, 3'd0, 8'h00, 8'h00, 0, 2, 6'b000000);
      do_req(1, 0, 3'd1, 8'h00, 8'h33, 0, 2, 6'b000000);
`endif

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
